// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall, multi-source flush,
// optional 2-entry skid buffer and a saturating squash counter.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 96,
  parameter int unsigned       NUM_FLUSH  = 2,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       SKID       = 1,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 up_valid_i,
  output logic                 up_ready_o,
  input  logic [DATA_W-1:0]    up_data_i,
  input  logic                 stall_i,
  input  logic [NUM_FLUSH-1:0] flush_i,
  output logic                 dn_valid_o,
  input  logic                 dn_ready_i,
  output logic [DATA_W-1:0]    dn_data_o,
  output logic [1:0]           occ_o,
  output logic [CNT_W-1:0]     flush_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e              state_q;
  logic              mv_q;
  logic              sv_q;
  logic [DATA_W-1:0] md_q;
  logic [DATA_W-1:0] sd_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              flush_any;
  logic              fire_dn;
  logic              fire_up;
  logic [CNT_W:0]    cnt_sum;
  logic [CNT_W-1:0]  cnt_next;

  assign flush_any = |flush_i;
  assign fire_dn   = mv_q & dn_ready_i & ~stall_i;

  generate
    if (SKID != 0) begin : g_skid
      // Ready depends only on the skid flag, so no combinational path from dn_ready_i.
      assign up_ready_o = ~rst_i & ~sv_q;
    end else begin : g_noskid
      assign up_ready_o = ~rst_i & (~mv_q | (dn_ready_i & ~stall_i));
    end
  endgenerate

  assign fire_up = up_valid_i & up_ready_o;

  // One spare bit catches the carry; any carry means the counter saturates.
  assign cnt_sum  = {1'b0, cnt_q} + (CNT_W+1)'(mv_q) + (CNT_W+1)'(sv_q);
  assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      mv_q    <= 1'b0;
      sv_q    <= 1'b0;
      md_q    <= BUBBLE_VAL;
      sd_q    <= BUBBLE_VAL;
      cnt_q   <= '0;
    end else if (flush_any) begin
      state_q <= EMPTY;
      mv_q    <= 1'b0;
      sv_q    <= 1'b0;
      md_q    <= BUBBLE_VAL;
      sd_q    <= BUBBLE_VAL;
      cnt_q   <= cnt_next;
    end else begin
      case (state_q)
        EMPTY: begin
          if (fire_up) begin
            md_q    <= up_data_i;
            mv_q    <= 1'b1;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (fire_up && fire_dn) begin
            md_q <= up_data_i;
          end else if (fire_up && (SKID != 0)) begin
            sd_q    <= up_data_i;
            sv_q    <= 1'b1;
            state_q <= FULL;
          end else if (fire_dn) begin
            md_q    <= BUBBLE_VAL;
            mv_q    <= 1'b0;
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (fire_dn) begin
            md_q    <= sd_q;
            sd_q    <= BUBBLE_VAL;
            sv_q    <= 1'b0;
            state_q <= ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
          mv_q    <= 1'b0;
          sv_q    <= 1'b0;
          md_q    <= BUBBLE_VAL;
          sd_q    <= BUBBLE_VAL;
        end
      endcase
    end
  end

  assign dn_valid_o  = mv_q;
  assign dn_data_o   = md_q;
  assign occ_o       = state_q;
  assign flush_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (default, CNT_W=2, SKID=0) share stimulus;
// a FIFO-occupancy reference model tracks each one.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        uv;
  logic [95:0] ud;
  logic        st;
  logic [1:0]  fl;
  logic        dr;

  logic        up_rdy [3];
  logic        dv     [3];
  logic [95:0] dd     [3];
  logic [1:0]  occ    [3];
  logic [15:0] c0;
  logic [1:0]  c1;
  logic [15:0] c2;

  int unsigned total;
  int unsigned bad;

  logic [95:0] m_e   [3][2];
  int unsigned m_n   [3];
  int unsigned m_c   [3];
  logic        m_rdy [3];
  logic        rdy_seen [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg u0 (
    .clk_i(clk), .rst_i(rst), .up_valid_i(uv), .up_ready_o(up_rdy[0]), .up_data_i(ud),
    .stall_i(st), .flush_i(fl), .dn_valid_o(dv[0]), .dn_ready_i(dr), .dn_data_o(dd[0]),
    .occ_o(occ[0]), .flush_cnt_o(c0));

  pipe_stage_reg #(.CNT_W(2)) u1 (
    .clk_i(clk), .rst_i(rst), .up_valid_i(uv), .up_ready_o(up_rdy[1]), .up_data_i(ud),
    .stall_i(st), .flush_i(fl), .dn_valid_o(dv[1]), .dn_ready_i(dr), .dn_data_o(dd[1]),
    .occ_o(occ[1]), .flush_cnt_o(c1));

  pipe_stage_reg #(.SKID(0)) u2 (
    .clk_i(clk), .rst_i(rst), .up_valid_i(uv), .up_ready_o(up_rdy[2]), .up_data_i(ud),
    .stall_i(st), .flush_i(fl), .dn_valid_o(dv[2]), .dn_ready_i(dr), .dn_data_o(dd[2]),
    .occ_o(occ[2]), .flush_cnt_o(c2));

  function automatic int unsigned cnt_of(input int k);
    if (k == 0) return int'(c0);
    if (k == 1) return int'(c1);
    return int'(c2);
  endfunction

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic step(input logic r, input logic v, input logic [95:0] d,
                      input logic s, input logic [1:0] f, input logic rd);
    logic fu;
    logic fd;
    int unsigned cmax;
    rst = r; uv = v; ud = d; st = s; fl = f; dr = rd;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (r) m_rdy[k] = 1'b0;
      else if (k == 2) m_rdy[k] = (m_n[k] == 0) || (rd && !s);
      else m_rdy[k] = (m_n[k] < 2);
      rdy_seen[k] = up_rdy[k];
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      cmax = (k == 1) ? 3 : 65535;
      fu = v && m_rdy[k];
      fd = (m_n[k] > 0) && rd && !s;
      if (r) begin
        m_n[k] = 0;
        m_c[k] = 0;
      end else if (|f) begin
        m_c[k] = (m_c[k] + m_n[k] > cmax) ? cmax : m_c[k] + m_n[k];
        m_n[k] = 0;
      end else begin
        if (fd) begin
          m_e[k][0] = m_e[k][1];
          m_n[k] = m_n[k] - 1;
        end
        if (fu) begin
          m_e[k][m_n[k]] = d;
          m_n[k] = m_n[k] + 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rd);
    step(1'b0, 1'b0, 96'h0, 1'b0, 2'b00, rd);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 96'h0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    total++; if (dv[0] !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", dv[0]); end
    total++; if (dd[0] !== 96'h0) begin bad++; $display("FAIL reset_data got=%h want=0", dd[0]); end
    total++; if (occ[0] !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occ[0]); end
    total++; if (c0 !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", c0); end
    total++; if (rdy_seen[0] !== 1'b0) begin bad++; $display("FAIL reset_ready_forced got=%b want=0", rdy_seen[0]); end
    idle(1'b1);
    total++; if (rdy_seen[0] !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b want=1", rdy_seen[0]); end
    total++; if (rdy_seen[2] !== 1'b1) begin bad++; $display("FAIL ready_after_reset_s0 got=%b want=1", rdy_seen[2]); end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 96'(i), 1'b0, 2'b00, 1'b1);
      total++; if (dd[0] !== 96'(i)) begin bad++; $display("FAIL stream_data i=%0d got=%h want=%h", i, dd[0], 96'(i)); end
      total++; if (dv[0] !== 1'b1 || occ[0] !== 2'd1) begin bad++; $display("FAIL stream_valid_occ i=%0d got=%b/%0d want=1/1", i, dv[0], occ[0]); end
    end
    idle(1'b1);
    total++; if (dv[0] !== 1'b0 || dd[0] !== 96'h0) begin bad++; $display("FAIL stream_drain got=%b/%h want=0/0", dv[0], dd[0]); end
  endtask

  task automatic test_backpressure();
    step(1'b0, 1'b1, 96'hA, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 96'hB, 1'b0, 2'b00, 1'b0);
    total++; if (occ[0] !== 2'd2) begin bad++; $display("FAIL bp_full_occ got=%0d want=2", occ[0]); end
    total++; if (up_rdy[0] !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", up_rdy[0]); end
    step(1'b0, 1'b1, 96'hC, 1'b0, 2'b00, 1'b0);
    total++; if (dd[0] !== 96'hA || occ[0] !== 2'd2) begin bad++; $display("FAIL bp_hold got=%h/%0d want=a/2", dd[0], occ[0]); end
    step(1'b0, 1'b1, 96'hC, 1'b0, 2'b00, 1'b1);
    total++; if (dd[0] !== 96'hB || occ[0] !== 2'd1) begin bad++; $display("FAIL bp_second got=%h/%0d want=b/1", dd[0], occ[0]); end
    step(1'b0, 1'b1, 96'hC, 1'b0, 2'b00, 1'b1);
    total++; if (dd[0] !== 96'hC || dv[0] !== 1'b1) begin bad++; $display("FAIL bp_third got=%h/%b want=c/1", dd[0], dv[0]); end
    idle(1'b1);
    total++; if (dv[0] !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", dv[0]); end
  endtask

  task automatic test_stall();
    step(1'b0, 1'b1, 96'h77, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 96'h0, 1'b1, 2'b00, 1'b1);
      total++; if (dd[0] !== 96'h77 || dv[0] !== 1'b1) begin bad++; $display("FAIL stall_hold i=%0d got=%h/%b want=77/1", i, dd[0], dv[0]); end
    end
    idle(1'b1);
    total++; if (dv[0] !== 1'b0 || dd[0] !== 96'h0) begin bad++; $display("FAIL stall_release got=%b/%h want=0/0", dv[0], dd[0]); end
  endtask

  task automatic test_flush_full();
    do_reset();
    step(1'b0, 1'b1, 96'h11, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 96'h22, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 96'hD, 1'b0, 2'b10, 1'b0);
    total++; if (dv[0] !== 1'b0 || dd[0] !== 96'h0 || occ[0] !== 2'd0) begin bad++; $display("FAIL flush_clear got=%b/%h/%0d want=0/0/0", dv[0], dd[0], occ[0]); end
    total++; if (c0 !== 16'd2) begin bad++; $display("FAIL flush_cnt2 got=%0d want=2", c0); end
    idle(1'b1);
    total++; if (dv[0] !== 1'b0) begin bad++; $display("FAIL flush_no_d got=%b want=0", dv[0]); end
    step(1'b0, 1'b1, 96'h33, 1'b0, 2'b00, 1'b1);
    step(1'b0, 1'b1, 96'hE, 1'b0, 2'b01, 1'b1);
    total++; if (dv[0] !== 1'b0 || c0 !== 16'd3) begin bad++; $display("FAIL flush_drop_beat got=%b/%0d want=0/3", dv[0], c0); end
    idle(1'b1);
    total++; if (dv[0] !== 1'b0) begin bad++; $display("FAIL flush_no_e got=%b want=0", dv[0]); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 96'h5, 1'b0, 2'b00, 1'b0);
      step(1'b0, 1'b0, 96'h0, 1'b0, 2'b01, 1'b0);
      total++; if (int'(c1) != ((i > 3) ? 3 : i)) begin bad++; $display("FAIL sat_cnt i=%0d got=%0d want=%0d", i, c1, (i > 3) ? 3 : i); end
    end
    idle(1'b1);
    total++; if (c1 !== 2'd3) begin bad++; $display("FAIL sat_hold got=%0d want=3", c1); end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 96'h1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 96'h2, 1'b0, 2'b00, 1'b0);
    step(1'b1, 1'b1, 96'h3, 1'b0, 2'b11, 1'b1);
    total++; if (dv[0] !== 1'b0 || dd[0] !== 96'h0 || occ[0] !== 2'd0) begin bad++; $display("FAIL rstmid_out got=%b/%h/%0d want=0/0/0", dv[0], dd[0], occ[0]); end
    total++; if (c0 !== 16'd0 || c1 !== 2'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d/%0d want=0/0", c0, c1); end
    idle(1'b1);
    total++; if (rdy_seen[0] !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", rdy_seen[0]); end
  endtask

  task automatic test_skid0();
    do_reset();
    step(1'b0, 1'b1, 96'h40, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 96'h41, 1'b0, 2'b00, 1'b0);
    total++; if (rdy_seen[2] !== 1'b0 || occ[2] !== 2'd1 || dd[2] !== 96'h40) begin bad++; $display("FAIL s0_bp got=%b/%0d/%h want=0/1/40", rdy_seen[2], occ[2], dd[2]); end
    dr = 1'b1; #1;
    total++; if (up_rdy[2] !== 1'b1) begin bad++; $display("FAIL s0_track_hi got=%b want=1", up_rdy[2]); end
    dr = 1'b0; #1;
    total++; if (up_rdy[2] !== 1'b0) begin bad++; $display("FAIL s0_track_lo got=%b want=0", up_rdy[2]); end
    step(1'b0, 1'b1, 96'h41, 1'b0, 2'b00, 1'b1);
    total++; if (dd[2] !== 96'h41 || occ[2] !== 2'd1) begin bad++; $display("FAIL s0_pass got=%h/%0d want=41/1", dd[2], occ[2]); end
  endtask

  task automatic test_random();
    logic [95:0] exp_d;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 70), {$urandom, $urandom, $urandom},
           ($urandom_range(99) < 15), (($urandom_range(99) < 6) ? 2'($urandom_range(3, 1)) : 2'b00),
           ($urandom_range(99) < 60));
      for (int k = 0; k < 3; k++) begin
        exp_d = (m_n[k] > 0) ? m_e[k][0] : 96'h0;
        total++; if (rdy_seen[k] !== m_rdy[k]) begin bad++; $display("FAIL rnd_ready n=%0d u%0d got=%b want=%b", n, k, rdy_seen[k], m_rdy[k]); end
        total++; if (dv[k] !== (m_n[k] > 0)) begin bad++; $display("FAIL rnd_valid n=%0d u%0d got=%b want=%b", n, k, dv[k], m_n[k] > 0); end
        total++; if (dd[k] !== exp_d) begin bad++; $display("FAIL rnd_data n=%0d u%0d got=%h want=%h", n, k, dd[k], exp_d); end
        total++; if (int'(occ[k]) != m_n[k]) begin bad++; $display("FAIL rnd_occ n=%0d u%0d got=%0d want=%0d", n, k, occ[k], m_n[k]); end
        total++; if (cnt_of(k) != m_c[k]) begin bad++; $display("FAIL rnd_cnt n=%0d u%0d got=%0d want=%0d", n, k, cnt_of(k), m_c[k]); end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; uv = 1'b0; ud = '0; st = 1'b0; fl = '0; dr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_n[k] = 0; m_c[k] = 0; m_rdy[k] = 1'b0; rdy_seen[k] = 1'b0;
      m_e[k][0] = '0; m_e[k][1] = '0;
    end
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush_full();
    test_saturation();
    test_reset_mid();
    test_skid0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
